sccb_init_sequencer: RTL

//  Camera register-initialisation controller. Walks a register table and drives the SCCB

---
 rtl/sccb_init_sequencer_pkg.sv | 26 ++
 rtl/sccb_init_sequencer_if.sv | 20 ++
 rtl/sccb_init_sequencer_reg_rom.sv | 18 +
 rtl/sccb_init_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/sccb_init_sequencer_pkg.sv
// Shared types for the SCCB init sequencer: table entry layout, marker values, FSM states.
package sccb_init_sequencer_pkg;

  typedef struct packed {
    logic [7:0] sub_addr;
    logic [7:0] data;
  } entry_t;

  localparam logic [7:0] DLY_TAG  = 8'hFF;
  localparam entry_t     END_MARK = 16'hFFFF;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_DELAY,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_RELEASE,
    ST_CHECK,
    ST_GAP,
    ST_DONE,
    ST_ERROR
  } state_e;

endpackage

// File: rtl/sccb_init_sequencer_if.sv
// Request/response bundle between the init sequencer (master) and the SCCB core (slave).
interface sccb_init_sequencer_if;
  logic       sccb_start;
  logic       sccb_rw;
  logic [7:0] sccb_ip_addr;
  logic [7:0] sccb_sub_addr;
  logic [7:0] sccb_data_in;
  logic [7:0] sccb_data_out;
  logic       sccb_done;

  modport master (
    output sccb_start, sccb_rw, sccb_ip_addr, sccb_sub_addr, sccb_data_in,
    input  sccb_data_out, sccb_done
  );

  modport slave (
    input  sccb_start, sccb_rw, sccb_ip_addr, sccb_sub_addr, sccb_data_in,
    output sccb_data_out, sccb_done
  );
endinterface

// File: rtl/sccb_init_sequencer_reg_rom.sv
// Register table ROM: entry i lives at TABLE_INIT[16*i +: 16]; one-cycle synchronous read.
module sccb_init_sequencer_reg_rom
  import sccb_init_sequencer_pkg::*;
#(
  parameter int unsigned TBL_DEPTH = 64,
  parameter logic [TBL_DEPTH*16-1:0] TABLE_INIT = (TBL_DEPTH*16)'(48'hFFFF_1101_1280),
  localparam int unsigned IW = $clog2(TBL_DEPTH)
) (
  input  logic          clk_i,
  input  logic [IW-1:0] addr_i,
  output entry_t        entry_o
);

  always_ff @(posedge clk_i) begin
    entry_o <= TABLE_INIT[{addr_i, 4'b0000} +: 16];
  end

endmodule

// File: rtl/sccb_init_sequencer.sv
// Camera register-init sequencer: walks the register table issuing one SCCB transaction
// per entry, with optional read-back verify, bounded retries and millisecond delay entries.
module sccb_init_sequencer
  import sccb_init_sequencer_pkg::*;
#(
  parameter logic [7:0]  DEV_ID      = 8'h42,
  parameter int unsigned TBL_DEPTH   = 64,
  parameter bit          VERIFY      = 1'b1,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned MS_CYCLES   = 8000,
  parameter int unsigned GAP_CYCLES  = 800,
  parameter int unsigned TIMEOUT_CYC = 200000,
  parameter logic [7:0]  NOVFY_ADDR  = 8'h12,
  parameter logic [TBL_DEPTH*16-1:0] TABLE_INIT = (TBL_DEPTH*16)'(48'hFFFF_1101_1280),
  localparam int unsigned IW = $clog2(TBL_DEPTH)
) (
  input  logic                  XCLK,
  input  logic                  RST,
  input  logic                  init_go,
  sccb_init_sequencer_if.master sccb,
  output logic                  busy,
  output logic                  init_done,
  output logic                  init_err,
  output logic [IW-1:0]         err_index
);

  localparam int unsigned IXW     = IW + 1;
  localparam int unsigned RTW     = $clog2(MAX_RETRY + 1);
  localparam int unsigned DLY_MAX = 255 * MS_CYCLES;
  localparam int unsigned CNT_A   = (TIMEOUT_CYC > DLY_MAX) ? TIMEOUT_CYC : DLY_MAX;
  localparam int unsigned CNT_MAX = (CNT_A > GAP_CYCLES) ? CNT_A : GAP_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  state_e         state_q, state_d;
  logic [IXW-1:0] idx_q, idx_d;
  logic [RTW-1:0] retry_q, retry_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [7:0]     sub_q, sub_d, data_q, data_d, rdata_q, rdata_d;
  logic           fail_q, fail_d;
  logic [IW-1:0]  err_idx_q, err_idx_d;
  logic           start_q, start_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic           pass_c;
  entry_t         rom_entry;

  sccb_init_sequencer_reg_rom #(
    .TBL_DEPTH  (TBL_DEPTH),
    .TABLE_INIT (TABLE_INIT)
  ) u_rom (
    .clk_i   (XCLK),
    .addr_i  (idx_q[IW-1:0]),
    .entry_o (rom_entry)
  );

  // A timed-out attempt never passes; the self-clearing register is never compared.
  assign pass_c = !fail_q && (!VERIFY || (sub_q == NOVFY_ADDR) || (rdata_q == data_q));

  always_ff @(posedge XCLK or posedge RST) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state plus datapath; one down-counter serves DELAY, GAP and the done timeout.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    cnt_d     = cnt_q;
    sub_d     = sub_q;
    data_d    = data_q;
    rdata_d   = rdata_q;
    fail_d    = fail_q;
    err_idx_d = err_idx_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (init_go) begin
          state_d = ST_FETCH;
          idx_d   = '0;
          retry_d = '0;
        end
      end
      ST_FETCH: state_d = (idx_q == IXW'(TBL_DEPTH)) ? ST_DONE : ST_DECODE;
      ST_DECODE: begin
        if (rom_entry == END_MARK) begin
          state_d = ST_DONE;
        end else if (rom_entry.sub_addr == DLY_TAG) begin
          if (rom_entry.data == 8'h00) begin
            state_d = ST_FETCH;
            idx_d   = idx_q + IXW'(1);
          end else begin
            state_d = ST_DELAY;
            cnt_d   = CW'(rom_entry.data * MS_CYCLES);
          end
        end else begin
          state_d = ST_ISSUE;
          sub_d   = rom_entry.sub_addr;
          data_d  = rom_entry.data;
          fail_d  = 1'b0;
        end
      end
      ST_DELAY: begin
        if (cnt_q <= CW'(1)) begin
          state_d = ST_FETCH;
          idx_d   = idx_q + IXW'(1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_DONE;
        cnt_d   = CW'(TIMEOUT_CYC);
      end
      ST_WAIT_DONE: begin
        if (sccb.sccb_done) begin
          state_d = ST_RELEASE;
          rdata_d = sccb.sccb_data_out;
        end else if (cnt_q <= CW'(1)) begin
          state_d = ST_RELEASE;
          fail_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RELEASE: if (!sccb.sccb_done) state_d = ST_CHECK;
      ST_CHECK: begin
        if (pass_c) begin
          state_d = ST_GAP;
          idx_d   = idx_q + IXW'(1);
          retry_d = '0;
          cnt_d   = CW'(GAP_CYCLES);
        end else if (retry_q == RTW'(MAX_RETRY - 1)) begin
          state_d   = ST_ERROR;
          err_idx_d = idx_q[IW-1:0];
        end else begin
          state_d = ST_GAP;
          retry_d = retry_q + RTW'(1);
          cnt_d   = CW'(GAP_CYCLES);
        end
      end
      ST_GAP: begin
        if (cnt_q <= CW'(1)) state_d = ST_FETCH;
        else                 cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the next state so their registers line up with state_q.
  always_comb begin
    start_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    start_d = (state_d == ST_ISSUE) || (state_d == ST_WAIT_DONE);
    busy_d  = !(state_d inside {ST_IDLE, ST_DONE, ST_ERROR});
    done_d  = (state_d == ST_DONE);
    err_d   = (state_d == ST_ERROR);
  end

  always_ff @(posedge XCLK or posedge RST) begin
    if (RST) begin
      idx_q     <= '0;
      retry_q   <= '0;
      cnt_q     <= '0;
      sub_q     <= '0;
      data_q    <= '0;
      rdata_q   <= '0;
      fail_q    <= 1'b0;
      err_idx_q <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      retry_q   <= retry_d;
      cnt_q     <= cnt_d;
      sub_q     <= sub_d;
      data_q    <= data_d;
      rdata_q   <= rdata_d;
      fail_q    <= fail_d;
      err_idx_q <= err_idx_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign sccb.sccb_start    = start_q;
  assign sccb.sccb_rw       = VERIFY;
  assign sccb.sccb_ip_addr  = DEV_ID;
  assign sccb.sccb_sub_addr = sub_q;
  assign sccb.sccb_data_in  = data_q;
  assign busy               = busy_q;
  assign init_done          = done_q;
  assign init_err           = err_q;
  assign err_index          = err_idx_q;

endmodule
